// File: rtl/lcd_pkg.sv
// Shared types, timing constants and helpers for the LCD byte sequencer.
// LCD_SEQ_BUSY_POLL_EN selects busy-flag polling instead of fixed post-byte delays.
package lcd_pkg;

   localparam int unsigned TIMER_W  = 21;
   localparam int unsigned STEP_W   = 4;
   localparam int unsigned INIT_LEN = 9;

   // 50 MHz timing constants, shared with the transfer stage
   localparam int unsigned T_POWER_ON   = 1_000_000;
   localparam int unsigned T_INIT_LONG  = 250_000;
   localparam int unsigned T_INIT_SHORT = 5_000;
   localparam int unsigned T_CMD        = 2_500;
   localparam int unsigned T_CLEAR      = 100_000;

`ifdef LCD_SEQ_BUSY_POLL_EN
   localparam bit BUSY_POLL = 1'b1;
`else
   localparam bit BUSY_POLL = 1'b0;
`endif

   typedef enum logic [2:0] {
      PWR_WAIT,
      ISSUE,
      WAIT_DONE,
      GAP,
      DELAY,
      IDLE
   } state_t;

   typedef struct packed {
      logic               is_nibble;
      logic [7:0]         value;
      logic [TIMER_W-1:0] wait_cycles;
   } init_step_t;

   typedef struct packed {
      logic [3:0]         cmd;
      logic               rs;
      logic               rb;
      logic               m4;
      logic               hi;
      logic [7:0]         data;
      logic [TIMER_W-1:0] wait_cycles;
   } issue_t;

   // Settle time after a whole byte; clear/home commands need the long wait
   function automatic logic [TIMER_W-1:0] byte_wait(input logic [7:0] data, input logic rs,
                                                    input int unsigned cmd_w,
                                                    input int unsigned clear_w);
      if (BUSY_POLL)
         return '0;
      if (!rs && (data == 8'h01 || data == 8'h02))
         return TIMER_W'(clear_w);
      return TIMER_W'(cmd_w);
   endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// HD44780 4-bit power-on init table: step index -> step record.
// Byte-step waits collapse to 0 when LCD_SEQ_BUSY_POLL_EN is defined.
module lcd_init_rom
   import lcd_pkg::*;
#(
   parameter int unsigned INIT_WAIT_LONG  = T_INIT_LONG,
   parameter int unsigned INIT_WAIT_SHORT = T_INIT_SHORT,
   parameter int unsigned CMD_WAIT        = T_CMD,
   parameter int unsigned CLEAR_WAIT      = T_CLEAR
) (
   input  logic [STEP_W-1:0] idx,
   output init_step_t        step
);

   function automatic init_step_t byte_step(input logic [7:0] v);
      return '{is_nibble: 1'b0, value: v,
               wait_cycles: byte_wait(v, 1'b0, CMD_WAIT, CLEAR_WAIT)};
   endfunction

   always_comb begin
      step = '{is_nibble: 1'b1, value: 8'h00, wait_cycles: '0};
      case (idx)
         4'd0:    step = '{is_nibble: 1'b1, value: 8'h03, wait_cycles: TIMER_W'(INIT_WAIT_LONG)};
         4'd1:    step = '{is_nibble: 1'b1, value: 8'h03, wait_cycles: TIMER_W'(INIT_WAIT_SHORT)};
         4'd2:    step = '{is_nibble: 1'b1, value: 8'h03, wait_cycles: TIMER_W'(INIT_WAIT_SHORT)};
         4'd3:    step = '{is_nibble: 1'b1, value: 8'h02, wait_cycles: TIMER_W'(INIT_WAIT_SHORT)};
         4'd4:    step = byte_step(8'h28);
         4'd5:    step = byte_step(8'h08);
         4'd6:    step = byte_step(8'h01);
         4'd7:    step = byte_step(8'h06);
         4'd8:    step = byte_step(8'h0C);
         default: ;
      endcase
   end

endmodule

// File: rtl/lcd_byte_sequencer.sv
// Runs the LCD power-on init, then splits accepted bytes into nibbles for lcd_transfer.
// LCD_SEQ_BUSY_POLL_EN: low nibbles request a busy poll and byte delays become 0.
module lcd_byte_sequencer
   import lcd_pkg::*;
#(
   parameter int unsigned POWER_ON_WAIT   = T_POWER_ON,
   parameter int unsigned INIT_WAIT_LONG  = T_INIT_LONG,
   parameter int unsigned INIT_WAIT_SHORT = T_INIT_SHORT,
   parameter int unsigned CMD_WAIT        = T_CMD,
   parameter int unsigned CLEAR_WAIT      = T_CLEAR
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               byte_valid,
   input  logic [7:0]         byte_data,
   input  logic               byte_rs,
   output logic               byte_ready,
   output logic               init_done,
   output logic               sendCommand,
   output logic [3:0]         command,
   output logic               command_rs,
   output logic [TIMER_W-1:0] commandDelay,
   output logic               read_busy,
   output logic               mode4bit,
   input  logic               commandDone
);

   state_t             state;
   logic [TIMER_W-1:0] timer;
   logic [STEP_W-1:0]  step;
   logic [STEP_W-1:0]  rom_idx;
   logic [7:0]         data_q;
   logic               rs_q;
   logic               hi_sent;
   init_step_t         rom_step;
   issue_t             iss;
   logic               last_step;
   logic               delay_done;
   logic               advance;
   logic               issue_now;

   lcd_init_rom #(
      .INIT_WAIT_LONG  (INIT_WAIT_LONG),
      .INIT_WAIT_SHORT (INIT_WAIT_SHORT),
      .CMD_WAIT        (CMD_WAIT),
      .CLEAR_WAIT      (CLEAR_WAIT)
   ) u_rom (
      .idx  (rom_idx),
      .step (rom_step)
   );

   // Payload of whichever nibble is issued next
   always_comb begin
      rom_idx = (state == PWR_WAIT) ? '0 : step + STEP_W'(1);
      iss = '{cmd: rom_step.value[3:0], rs: 1'b0, rb: 1'b0, m4: 1'b0, hi: 1'b0,
              data: rom_step.value, wait_cycles: rom_step.wait_cycles};
      if (state == IDLE)
         iss = '{cmd: byte_data[7:4], rs: byte_rs, rb: 1'b0, m4: 1'b1, hi: 1'b1, data: byte_data,
                 wait_cycles: byte_wait(byte_data, byte_rs, CMD_WAIT, CLEAR_WAIT)};
      else if (state == GAP && hi_sent)
         iss = '{cmd: data_q[3:0], rs: rs_q, rb: BUSY_POLL, m4: 1'b1, hi: 1'b0, data: data_q,
                 wait_cycles: commandDelay};
      else if (!rom_step.is_nibble)
         iss = '{cmd: rom_step.value[7:4], rs: 1'b0, rb: 1'b0, m4: 1'b1, hi: 1'b1,
                 data: rom_step.value, wait_cycles: rom_step.wait_cycles};
   end

   assign last_step  = (step == STEP_W'(INIT_LEN - 1));
   assign delay_done = (timer == commandDelay - TIMER_W'(1));
   assign advance    = (state == GAP && !hi_sent && commandDelay == '0) ||
                       (state == DELAY && delay_done);
   assign issue_now  = (state == PWR_WAIT && timer == TIMER_W'(POWER_ON_WAIT - 1)) ||
                       (state == GAP && hi_sent) ||
                       (state == IDLE && byte_valid && byte_ready) ||
                       (advance && !init_done && !last_step);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state        <= PWR_WAIT;
         timer        <= '0;
         step         <= '0;
         data_q       <= '0;
         rs_q         <= 1'b0;
         hi_sent      <= 1'b0;
         byte_ready   <= 1'b0;
         init_done    <= 1'b0;
         sendCommand  <= 1'b0;
         command      <= '0;
         command_rs   <= 1'b0;
         commandDelay <= '0;
         read_busy    <= 1'b0;
         mode4bit     <= 1'b0;
      end else begin
         sendCommand <= 1'b0;
         case (state)
            PWR_WAIT:  timer <= timer + TIMER_W'(1);
            ISSUE:     state <= WAIT_DONE;
            WAIT_DONE: if (commandDone) state <= GAP;
            GAP: begin
               if (!hi_sent && commandDelay != '0) begin
                  state <= DELAY;
                  timer <= '0;
               end
            end
            DELAY:     timer <= timer + TIMER_W'(1);
            IDLE:      ;
            default:   state <= PWR_WAIT;
         endcase

         // Step finished: next init step, or settle in IDLE
         if (advance) begin
            if (init_done || last_step) begin
               state      <= IDLE;
               byte_ready <= 1'b1;
               init_done  <= 1'b1;
            end else begin
               step <= step + STEP_W'(1);
            end
         end

         if (issue_now) begin
            state        <= ISSUE;
            timer        <= '0;
            byte_ready   <= 1'b0;
            sendCommand  <= 1'b1;
            command      <= iss.cmd;
            command_rs   <= iss.rs;
            read_busy    <= iss.rb;
            mode4bit     <= iss.m4;
            commandDelay <= iss.wait_cycles;
            hi_sent      <= iss.hi;
            data_q       <= iss.data;
            rs_q         <= iss.rs;
         end
      end
   end

endmodule

// File: tb/tb_lcd_byte_sequencer.sv
// Directed bench for lcd_byte_sequencer with a 5-cycle transfer-stage model.
// Expectations follow LCD_SEQ_BUSY_POLL_EN when it is defined for the build.
module tb_lcd_byte_sequencer;

   localparam int unsigned P_PWR   = 100;
   localparam int unsigned P_LONG  = 50;
   localparam int unsigned P_SHORT = 10;
   localparam int unsigned P_CMD   = 8;
   localparam int unsigned P_CLR   = 20;
`ifdef LCD_SEQ_BUSY_POLL_EN
   localparam bit POLL = 1'b1;
`else
   localparam bit POLL = 1'b0;
`endif

   typedef struct {
      int          cyc;
      logic [3:0]  cmd;
      logic        rs;
      logic        rb;
      logic        m4;
      logic [20:0] dly;
   } snd_t;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        byte_rs = 1'b0;
   logic        byte_ready;
   logic        init_done;
   logic        sendCommand;
   logic [3:0]  command;
   logic        command_rs;
   logic [20:0] commandDelay;
   logic        read_busy;
   logic        mode4bit;
   logic        commandDone;
   logic        model_done = 1'b0;
   logic        spur_done = 1'b0;
   int          model_cnt = 0;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_errs = 0;
   int   b2b = 0;
   int   init_rise = -1;
   int   rel = 0;
   int   n_before = 0;
   snd_t sends[$];
   int   dones[$];
   int   rdy_rise[$];
   logic prev_sc = 1'b0;
   logic prev_rdy = 1'b0;
   logic prev_init = 1'b0;

   assign commandDone = model_done | spur_done;

   lcd_byte_sequencer #(
      .POWER_ON_WAIT   (P_PWR),
      .INIT_WAIT_LONG  (P_LONG),
      .INIT_WAIT_SHORT (P_SHORT),
      .CMD_WAIT        (P_CMD),
      .CLEAR_WAIT      (P_CLR)
   ) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .byte_valid   (byte_valid),
      .byte_data    (byte_data),
      .byte_rs      (byte_rs),
      .byte_ready   (byte_ready),
      .init_done    (init_done),
      .sendCommand  (sendCommand),
      .command      (command),
      .command_rs   (command_rs),
      .commandDelay (commandDelay),
      .read_busy    (read_busy),
      .mode4bit     (mode4bit),
      .commandDone  (commandDone)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Transfer stage: commandDone 5 cycles after sendCommand
   always @(posedge CLK) begin
      if (RESET) begin
         model_cnt  <= 0;
         model_done <= 1'b0;
      end else begin
         model_done <= 1'b0;
         if (sendCommand) model_cnt <= 4;
         else if (model_cnt == 1) begin
            model_done <= 1'b1;
            model_cnt  <= 0;
         end else if (model_cnt != 0) model_cnt <= model_cnt - 1;
      end
   end

   // Event recorder, sampled 1 time unit after each edge
   always @(posedge CLK) begin
      #1;
      if (sendCommand) begin
         if (prev_sc) b2b++;
         sends.push_back('{cyc, command, command_rs, read_busy, mode4bit, commandDelay});
      end
      if (model_done) dones.push_back(cyc);
      if (byte_ready && !prev_rdy) rdy_rise.push_back(cyc);
      if (init_done && !prev_init) init_rise = cyc;
      prev_sc   = sendCommand;
      prev_rdy  = byte_ready;
      prev_init = init_done;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got time %0t required < 1000000", $time);
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic clear_log();
      sends.delete();
      dones.delete();
      rdy_rise.delete();
      init_rise = -1;
   endtask

   function automatic logic [31:0] outs_vec();
      return 32'({sendCommand, command, command_rs, commandDelay, read_busy, mode4bit,
                  byte_ready, init_done});
   endfunction

   task automatic run_init(input int r);
      int         bw;
      int         bc;
      int         gap [14];
      logic [3:0] exp_cmd [14];
      bw = POLL ? 0 : 8;
      bc = POLL ? 0 : 20;
      gap = '{50, 10, 10, 10, 0, bw, 0, bw, 0, bc, 0, bw, 0, bw};
      exp_cmd = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0, 4'h6,
                  4'h0, 4'hC};
      for (int k = 0; k < 3000 && init_rise < 0; k++) tick();
      check("init_finished", 32'(init_rise >= 0), 1);
      check("init_send_count", 32'(sends.size()), 14);
      check("first_send_cycle", 32'(sends[0].cyc), 32'(r + 100));
      check("first_send_delay", 32'(sends[0].dly), 50);
      check("clear_lo_delay", 32'(sends[9].dly), 32'(bc));
      for (int i = 0; i < sends.size() && i < 14; i++) begin
         check($sformatf("init_cmd%0d", i), 32'(sends[i].cmd), 32'(exp_cmd[i]));
         check($sformatf("init_m4_%0d", i), 32'(sends[i].m4), 32'(i >= 4));
         check($sformatf("init_rb_%0d", i), 32'(sends[i].rb),
               32'((i >= 5 && (i % 2) == 1) ? POLL : 1'b0));
         check($sformatf("init_rs_%0d", i), 32'(sends[i].rs), 0);
         if (i > 0)
            check($sformatf("init_time%0d", i), 32'(sends[i].cyc), 32'(dones[i-1] + 2 + gap[i-1]));
      end
      check("init_done_time", 32'(init_rise), 32'(dones[13] + 2 + gap[13]));
      check("ready_with_init", 32'(rdy_rise[0]), 32'(init_rise));
   endtask

   task automatic send_byte(input logic [7:0] d, input logic rs, input int wfix);
      int t;
      int w;
      w = POLL ? 0 : wfix;
      clear_log();
      check($sformatf("ready_before_%0h", d), 32'(byte_ready), 1);
      byte_valid = 1'b1;
      byte_data  = d;
      byte_rs    = rs;
      t = cyc;
      tick();
      byte_valid = 1'b0;
      check($sformatf("hs_send_%0h", d), 32'(sendCommand), 1);
      check($sformatf("hs_ready_low_%0h", d), 32'(byte_ready), 0);
      for (int k = 0; k < 300 && rdy_rise.size() == 0; k++) tick();
      check($sformatf("byte_sends_%0h", d), 32'(sends.size()), 2);
      check($sformatf("hi_time_%0h", d), 32'(sends[0].cyc), 32'(t + 1));
      check($sformatf("hi_cmd_%0h", d), 32'(sends[0].cmd), 32'(d[7:4]));
      check($sformatf("lo_cmd_%0h", d), 32'(sends[1].cmd), 32'(d[3:0]));
      check($sformatf("rs_%0h", d), 32'({sends[0].rs, sends[1].rs}), 32'({rs, rs}));
      check($sformatf("rb_%0h", d), 32'({sends[0].rb, sends[1].rb}), 32'({1'b0, POLL}));
      check($sformatf("m4_%0h", d), 32'({sends[0].m4, sends[1].m4}), 3);
      check($sformatf("lo_delay_%0h", d), 32'(sends[1].dly), 32'(w));
      check($sformatf("lo_time_%0h", d), 32'(sends[1].cyc), 32'(dones[0] + 2));
      check($sformatf("ready_time_%0h", d), 32'(rdy_rise[0]), 32'(dones[1] + 2 + w));
   endtask

   initial begin
      repeat (3) tick();
      check("reset_outs", outs_vec(), 0);
      RESET = 1'b0;
      rel = cyc;
      run_init(rel);

      send_byte(8'h41, 1'b1, 8);
      send_byte(8'h01, 1'b0, 20);
      send_byte(8'h02, 1'b0, 20);
      send_byte(8'h01, 1'b1, 8);

      // Reset while the high nibble of a byte is in flight
      byte_valid = 1'b1;
      byte_data  = 8'h55;
      byte_rs    = 1'b1;
      tick();
      byte_valid = 1'b0;
      tick();
      tick();
      RESET = 1'b1;
      tick();
      check("midrst_outs", outs_vec(), 0);
      tick();
      clear_log();
      RESET = 1'b0;
      rel = cyc;
      repeat (20) tick();
      spur_done = 1'b1;
      tick();
      spur_done = 1'b0;
      run_init(rel);

      n_before = sends.size();
      spur_done = 1'b1;
      tick();
      spur_done = 1'b0;
      repeat (10) tick();
      check("spur_idle_nosend", 32'(sends.size()), 32'(n_before));
      check("spur_idle_ready", 32'(byte_ready), 1);

      send_byte(8'h0C, 1'b0, 8);
      check("no_back_to_back", 32'(b2b), 0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
